// File: rtl/rollover_match_window_pkg.sv
// rollover_match_window_pkg: shared FSM encoding and default sizes for the match window block
package rollover_match_window_pkg;
  localparam int WIDTH_DEF = 12;
  localparam int NCH_DEF = 4;
  localparam int ID_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/rollover_match_window_addsub.sv
// rollover_addsub: modular add/sub modulo (r_i+1); computed in WIDTH+1 bits so r_i=2^WIDTH-1 cannot overflow
module rollover_addsub #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] y_o
);
  localparam logic [WIDTH:0] ONE = 1;
  logic [WIDTH:0] a, b, r, sum;
  assign a = {1'b0, a_i};
  assign b = {1'b0, b_i};
  assign r = {1'b0, r_i};
  assign sum = a + b;
  assign y_o = sub_i ? WIDTH'((a >= b) ? a - b : a + r + ONE - b)
                     : WIDTH'((sum > r) ? sum - r - ONE : sum);
endmodule

// File: rtl/rollover_match_window.sv
// rollover_match_window: wrapping coarse counter, trigger-driven match window and per-channel hit matcher
module rollover_match_window
  import rollover_match_window_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     rollover,
  input  logic [WIDTH-1:0]     match_offset,
  input  logic [WIDTH-1:0]     match_window,
  input  logic [WIDTH-1:0]     reject_margin,
  input  logic                 trig_valid,
  output logic                 trig_ready,
  input  logic [NCH-1:0]       hit_valid,
  input  logic [NCH*WIDTH-1:0] hit_time,
  output logic [WIDTH-1:0]     coarse_cnt,
  output logic                 win_active,
  output logic [WIDTH-1:0]     win_start,
  output logic [WIDTH-1:0]     win_end,
  output logic [NCH-1:0]       hit_match,
  output logic [NCH-1:0]       hit_err,
  output logic                 win_done,
  output logic [ID_W-1:0]      trig_id
);
  state_e state_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, t0_q, r_q, off_q, win_q, mar_q;
  logic [WIDTH-1:0] start_q, end_q, close_q, start_d, end_d, close_d;
  logic full_q, first_q, trig_ready_q, win_active_q, win_done_q;
  logic [ID_W-1:0] id_q;
  logic [NCH-1:0] match_q, match_d, err_q, err_d;
  // >= rather than == so a rollover lowered below the count wraps immediately
  assign cnt_d = !enable ? cnt_q : (cnt_q >= rollover) ? '0 : cnt_q + WIDTH'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  rollover_addsub #(.WIDTH(WIDTH)) u_start (
    .a_i(t0_q), .b_i(off_q), .r_i(r_q), .sub_i(1'b1), .y_o(start_d)
  );
  rollover_addsub #(.WIDTH(WIDTH)) u_end (
    .a_i(start_d), .b_i(win_q), .r_i(r_q), .sub_i(1'b0), .y_o(end_d)
  );
  rollover_addsub #(.WIDTH(WIDTH)) u_close (
    .a_i(end_d), .b_i(mar_q), .r_i(r_q), .sub_i(1'b0), .y_o(close_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_ready_q <= 1'b1;
      win_active_q <= 1'b0;
      win_done_q   <= 1'b0;
      id_q         <= '0;
      t0_q         <= '0;
      r_q          <= '0;
      off_q        <= '0;
      win_q        <= '0;
      mar_q        <= '0;
      start_q      <= '0;
      end_q        <= '0;
      close_q      <= '0;
      full_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (trig_valid) begin
          t0_q         <= cnt_q;
          r_q          <= rollover;
          off_q        <= match_offset;
          win_q        <= match_window;
          mar_q        <= reject_margin;
          id_q         <= id_q + ID_W'(1);
          trig_ready_q <= 1'b0;
          state_q      <= CALC;
        end
        CALC: begin
          start_q      <= start_d;
          end_q        <= end_d;
          close_q      <= close_d;
          full_q       <= win_q >= r_q;
          first_q      <= 1'b1;
          win_active_q <= 1'b1;
          state_q      <= ACTIVE;
        end
        // first ACTIVE cycle is skipped so close==t0+2 means a full wrap, not an instant exit
        ACTIVE: begin
          first_q <= 1'b0;
          if (!first_q && cnt_q == close_q) begin
            win_active_q <= 1'b0;
            win_done_q   <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          win_done_q   <= 1'b0;
          trig_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] t;
    logic in_win;
    assign t = hit_time[i*WIDTH +: WIDTH];
    assign in_win = full_q | ((start_q <= end_q) ? (t >= start_q && t <= end_q)
                                                 : (t >= start_q || t <= end_q));
    assign err_d[i] = hit_valid[i] & (t > r_q);
    assign match_d[i] = hit_valid[i] & in_win & ~err_d[i] & (state_q == ACTIVE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= '0;
      err_q   <= '0;
    end else begin
      match_q <= match_d;
      err_q   <= err_d;
    end
  end
  assign trig_ready = trig_ready_q;
  assign coarse_cnt = cnt_q;
  assign win_active = win_active_q;
  assign win_start  = start_q;
  assign win_end    = end_q;
  assign hit_match  = match_q;
  assign hit_err    = err_q;
  assign win_done   = win_done_q;
  assign trig_id    = id_q;
endmodule

// File: tb/tb_rollover_match_window.sv
// tb_rollover_match_window: directed scenario tasks with hand-computed expectations
module tb_rollover_match_window;
  localparam int W = 12;
  localparam int N = 4;
  localparam int IW = 8;
  logic clk = 1'b0;
  logic rst, enable, trig_valid, trig_ready, win_active, win_done;
  logic [W-1:0] rollover, match_offset, match_window, reject_margin;
  logic [W-1:0] coarse_cnt, win_start, win_end;
  logic [N-1:0] hit_valid, hit_match, hit_err;
  logic [N*W-1:0] hit_time;
  logic [IW-1:0] trig_id;
  int pass_cnt = 0;
  int total = 0;

  rollover_match_window #(.WIDTH(W), .NCH(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rollover(rollover),
    .match_offset(match_offset), .match_window(match_window), .reject_margin(reject_margin),
    .trig_valid(trig_valid), .trig_ready(trig_ready), .hit_valid(hit_valid), .hit_time(hit_time),
    .coarse_cnt(coarse_cnt), .win_active(win_active), .win_start(win_start), .win_end(win_end),
    .hit_match(hit_match), .hit_err(hit_err), .win_done(win_done), .trig_id(trig_id)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    trig_valid = 1'b0;
    hit_valid = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [W-1:0] r, o, w, m);
    rollover = r;
    match_offset = o;
    match_window = w;
    reject_margin = m;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    for (int i = 0; i < 5000; i++) begin
      if (coarse_cnt == v) return;
      tick;
    end
    total++;
    $display("FAIL wait_cnt timeout got %0d want %0d", coarse_cnt, v);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 5000; i++) begin
      if (win_done) return;
      tick;
    end
    total++;
    $display("FAIL wait_done timeout got win_done=%0b want 1", win_done);
  endtask

  task automatic fire(input logic [W-1:0] t0);
    wait_cnt(t0);
    trig_valid = 1'b1;
    tick;
    trig_valid = 1'b0;
  endtask

  task automatic hits(input logic [N-1:0] v, input logic [W-1:0] t0, t1, t2, t3);
    hit_valid = v;
    hit_time = {t3, t2, t1, t0};
    tick;
    hit_valid = '0;
  endtask

  task automatic test_reset;
    enable = 1'b1;
    cfg(12'd4095, 12'd0, 12'd10, 12'd0);
    hit_time = '0;
    rst = 1'b1;
    hit_valid = '0;
    trig_valid = 1'b1;
    tick;
    total++; if (trig_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", trig_ready); else pass_cnt++;
    total++; if ({win_active, win_done} !== 2'b00) $display("FAIL rst_flags got %b want 00", {win_active, win_done}); else pass_cnt++;
    total++; if ({hit_match, hit_err} !== 8'h00) $display("FAIL rst_hits got %h want 00", {hit_match, hit_err}); else pass_cnt++;
    total++; if ({coarse_cnt, win_start, win_end} !== 36'd0) $display("FAIL rst_values got %h want 0", {coarse_cnt, win_start, win_end}); else pass_cnt++;
    total++; if (trig_id !== 8'd0) $display("FAIL rst_id got %0d want 0", trig_id); else pass_cnt++;
    trig_valid = 1'b0;
    rst = 1'b0;
    tick;
    total++; if ({trig_ready, trig_id} !== 9'h100) $display("FAIL rst_trig_ignored got ready=%0b id=%0d want 1/0", trig_ready, trig_id); else pass_cnt++;
  endtask

  task automatic test_basic;
    do_reset;
    cfg(12'd4095, 12'd20, 12'd30, 12'd5);
    fire(12'd100);
    total++; if ({trig_ready, win_active} !== 2'b00) $display("FAIL t1_calc got %b want 00", {trig_ready, win_active}); else pass_cnt++;
    total++; if (trig_id !== 8'd1) $display("FAIL t1_id got %0d want 1", trig_id); else pass_cnt++;
    tick;
    total++; if (win_active !== 1'b1) $display("FAIL t1_active got %0b want 1", win_active); else pass_cnt++;
    total++; if (win_start !== 12'd80) $display("FAIL t1_start got %0d want 80", win_start); else pass_cnt++;
    total++; if (win_end !== 12'd110) $display("FAIL t1_end got %0d want 110", win_end); else pass_cnt++;
    hits(4'b1111, 12'd80, 12'd110, 12'd79, 12'd111);
    total++; if (hit_match !== 4'b0011) $display("FAIL t1_match got %b want 0011", hit_match); else pass_cnt++;
    total++; if (hit_err !== 4'b0000) $display("FAIL t1_err got %b want 0000", hit_err); else pass_cnt++;
    wait_cnt(12'd115);
    hits(4'b0001, 12'd90, 12'd0, 12'd0, 12'd0);
    total++; if ({win_done, win_active} !== 2'b10) $display("FAIL t1_close got done/active=%b want 10", {win_done, win_active}); else pass_cnt++;
    total++; if (coarse_cnt !== 12'd116) $display("FAIL t1_close_cnt got %0d want 116", coarse_cnt); else pass_cnt++;
    total++; if (hit_match !== 4'b0001) $display("FAIL t1_exit_hit got %b want 0001", hit_match); else pass_cnt++;
    total++; if ({win_start, win_end} !== {12'd80, 12'd110}) $display("FAIL t1_hold got %0d/%0d want 80/110", win_start, win_end); else pass_cnt++;
    tick;
    total++; if ({win_done, trig_ready} !== 2'b01) $display("FAIL t1_idle got done/ready=%b want 01", {win_done, trig_ready}); else pass_cnt++;
    hits(4'b1111, 12'd100, 12'd100, 12'd100, 12'd100);
    total++; if ({hit_match, hit_err} !== 8'h00) $display("FAIL t1_idle_hits got %h want 00", {hit_match, hit_err}); else pass_cnt++;
  endtask

  task automatic test_wrap;
    do_reset;
    cfg(12'd4095, 12'd20, 12'd40, 12'd5);
    fire(12'd10);
    hits(4'b1111, 12'd4090, 12'd5, 12'd31, 12'd4085);
    total++; if (hit_match !== 4'b0000) $display("FAIL t2_calc_hits got %b want 0000", hit_match); else pass_cnt++;
    total++; if ({win_start, win_end} !== {12'd4086, 12'd30}) $display("FAIL t2_window got %0d/%0d want 4086/30", win_start, win_end); else pass_cnt++;
    hits(4'b1111, 12'd4090, 12'd5, 12'd31, 12'd4085);
    total++; if (hit_match !== 4'b0011) $display("FAIL t2_match got %b want 0011", hit_match); else pass_cnt++;
    wait_done;
    total++; if (coarse_cnt !== 12'd36) $display("FAIL t2_close_cnt got %0d want 36", coarse_cnt); else pass_cnt++;
  endtask

  task automatic test_small_rollover;
    do_reset;
    cfg(12'd99, 12'd10, 12'd20, 12'd5);
    wait_cnt(12'd98);
    tick;
    total++; if (coarse_cnt !== 12'd99) $display("FAIL t3_cnt99 got %0d want 99", coarse_cnt); else pass_cnt++;
    tick;
    total++; if (coarse_cnt !== 12'd0) $display("FAIL t3_cnt_wrap got %0d want 0", coarse_cnt); else pass_cnt++;
    fire(12'd5);
    tick;
    total++; if ({win_start, win_end} !== {12'd95, 12'd15}) $display("FAIL t3_window got %0d/%0d want 95/15", win_start, win_end); else pass_cnt++;
    hits(4'b1111, 12'd120, 12'd97, 12'd50, 12'd99);
    total++; if (hit_match !== 4'b1010) $display("FAIL t3_match got %b want 1010", hit_match); else pass_cnt++;
    total++; if (hit_err !== 4'b0001) $display("FAIL t3_err got %b want 0001", hit_err); else pass_cnt++;
    wait_done;
    total++; if (coarse_cnt !== 12'd21) $display("FAIL t3_close_cnt got %0d want 21", coarse_cnt); else pass_cnt++;
    wait_cnt(12'd50);
    rollover = 12'd30;
    tick;
    total++; if (coarse_cnt !== 12'd0) $display("FAIL t3_lowered got %0d want 0", coarse_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int done_n = 0;
    do_reset;
    cfg(12'd4095, 12'd0, 12'd3, 12'd1);
    trig_valid = 1'b1;
    for (int c = 0; c < 200 && done_n < 3; c++) begin
      tick;
      if (win_done) begin
        done_n++;
        total++; if (trig_id !== IW'(done_n)) $display("FAIL t4_id got %0d want %0d", trig_id, done_n); else pass_cnt++;
      end
      if (win_done || win_active) begin
        total++; if (trig_ready !== 1'b0) $display("FAIL t4_ready_busy got %0b want 0", trig_ready); else pass_cnt++;
      end
    end
    trig_valid = 1'b0;
    total++; if (done_n !== 3) $display("FAIL t4_windows got %0d want 3", done_n); else pass_cnt++;
    tick;
    total++; if ({trig_ready, win_done, trig_id} !== {2'b10, 8'd3}) $display("FAIL t4_end got ready=%0b done=%0b id=%0d want 1/0/3", trig_ready, win_done, trig_id); else pass_cnt++;
  endtask

  task automatic test_full_window;
    do_reset;
    cfg(12'd4095, 12'd0, 12'd4095, 12'd5);
    fire(12'd20);
    tick;
    hits(4'b1111, 12'd0, 12'd4095, 12'd19, 12'd3000);
    total++; if (hit_match !== 4'b1111) $display("FAIL t5_full got %b want 1111", hit_match); else pass_cnt++;
    wait_done;
    total++; if (coarse_cnt !== 12'd25) $display("FAIL t5_close_cnt got %0d want 25", coarse_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_window;
    do_reset;
    cfg(12'd4095, 12'd0, 12'd100, 12'd0);
    fire(12'd5);
    tick;
    tick;
    total++; if (win_active !== 1'b1) $display("FAIL t6_pre got %0b want 1", win_active); else pass_cnt++;
    rst = 1'b1;
    hits(4'b1111, 12'd5, 12'd6, 12'd7, 12'd8);
    rst = 1'b0;
    total++; if ({trig_ready, win_active, win_done} !== 3'b100) $display("FAIL t6_flags got %b want 100", {trig_ready, win_active, win_done}); else pass_cnt++;
    total++; if ({coarse_cnt, trig_id} !== 20'd0) $display("FAIL t6_cnt_id got %0d/%0d want 0/0", coarse_cnt, trig_id); else pass_cnt++;
    total++; if (hit_match !== 4'b0000) $display("FAIL t6_match got %b want 0000", hit_match); else pass_cnt++;
    tick;
    total++; if ({win_done, win_active, trig_ready} !== 3'b001) $display("FAIL t6_after got %b want 001", {win_done, win_active, trig_ready}); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_small_rollover;
    test_back_to_back;
    test_full_window;
    test_reset_mid_window;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
